// File: rtl/mips_pkg.sv
// MIPS instruction field layout and opcode constants shared by fetch, queue and control.
package mips_pkg;

  localparam int INSTR_W    = 32;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int RS_MSB     = 25;
  localparam int RS_LSB     = 21;
  localparam int RT_MSB     = 20;
  localparam int RT_LSB     = 16;
  localparam int RD_MSB     = 15;
  localparam int RD_LSB     = 11;
  localparam int SHAMT_MSB  = 10;
  localparam int SHAMT_LSB  = 6;
  localparam int FUNCT_MSB  = 5;
  localparam int FUNCT_LSB  = 0;
  localparam int IMM_MSB    = 15;
  localparam int IMM_LSB    = 0;
  localparam int JT_MSB     = 25;
  localparam int JT_LSB     = 0;

  localparam int OPCODE_W   = OPCODE_MSB - OPCODE_LSB + 1;
  localparam int REG_W      = RS_MSB - RS_LSB + 1;
  localparam int SHAMT_W    = SHAMT_MSB - SHAMT_LSB + 1;
  localparam int FUNCT_W    = FUNCT_MSB - FUNCT_LSB + 1;
  localparam int IMM_W      = IMM_MSB - IMM_LSB + 1;
  localparam int JT_W       = JT_MSB - JT_LSB + 1;

  typedef enum logic [OPCODE_W-1:0] {
    OP_RTYPE = 6'h00,
    OP_J     = 6'h02,
    OP_JAL   = 6'h03,
    OP_BEQ   = 6'h04,
    OP_LW    = 6'h23,
    OP_SW    = 6'h2B
  } opcode_e;

  function automatic logic [INSTR_W-1:0] sext_imm(input logic [IMM_W-1:0] imm);
    return {{(INSTR_W-IMM_W){imm[IMM_W-1]}}, imm};
  endfunction

endpackage

// File: rtl/instr_queue_if.sv
// Fetch-side push, consumer-side pop and decoded head fields of the instruction queue.
interface instr_queue_if
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32,
  parameter int DEPTH  = 4
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                flush;
  logic                in_valid;
  logic                in_ready;
  logic [DATA_W-1:0]   in_instr;
  logic [PC_W-1:0]     in_pc;
  logic                out_valid;
  logic                out_ready;
  logic [DATA_W-1:0]   out_instr;
  logic [PC_W-1:0]     out_pc;
  logic [OPCODE_W-1:0] opcode;
  logic [REG_W-1:0]    rs;
  logic [REG_W-1:0]    rt;
  logic [REG_W-1:0]    rd;
  logic [SHAMT_W-1:0]  shamt;
  logic [FUNCT_W-1:0]  funct;
  logic [IMM_W-1:0]    imm;
  logic [INSTR_W-1:0]  imm_sext;
  logic [JT_W-1:0]     jump_target;
  logic [CNT_W-1:0]    count;

  modport master (
    output flush, in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_instr, out_pc, opcode, rs, rt, rd, shamt, funct,
           imm, imm_sext, jump_target, count
  );

  modport slave (
    input  flush, in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_instr, out_pc, opcode, rs, rt, rd, shamt, funct,
           imm, imm_sext, jump_target, count
  );
endinterface

// File: rtl/instr_field_decode.sv
// Combinational MIPS R/I/J field slicer with sign-extended immediate; zero latency.
module instr_field_decode
  import mips_pkg::*;
(
  input  logic [INSTR_W-1:0]  instr,
  output logic [OPCODE_W-1:0] opcode,
  output logic [REG_W-1:0]    rs,
  output logic [REG_W-1:0]    rt,
  output logic [REG_W-1:0]    rd,
  output logic [SHAMT_W-1:0]  shamt,
  output logic [FUNCT_W-1:0]  funct,
  output logic [IMM_W-1:0]    imm,
  output logic [INSTR_W-1:0]  imm_sext,
  output logic [JT_W-1:0]     jump_target
);

  assign opcode      = instr[OPCODE_MSB:OPCODE_LSB];
  assign rs          = instr[RS_MSB:RS_LSB];
  assign rt          = instr[RT_MSB:RT_LSB];
  assign rd          = instr[RD_MSB:RD_LSB];
  assign shamt       = instr[SHAMT_MSB:SHAMT_LSB];
  assign funct       = instr[FUNCT_MSB:FUNCT_LSB];
  assign imm         = instr[IMM_MSB:IMM_LSB];
  assign imm_sext    = sext_imm(instr[IMM_MSB:IMM_LSB]);
  assign jump_target = instr[JT_MSB:JT_LSB];

endmodule

// File: rtl/instr_queue.sv
// DEPTH-entry instruction/PC FIFO between fetch and decode; 1-cycle push-to-head latency, no bypass.
// in_ready drops when full (registered count only, no pass-through); flush beats push/pop.
module instr_queue
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int PC_W   = 32
)
(
  input logic           clock,
  input logic           reset,
  instr_queue_if.slave  q
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [DATA_W-1:0] instr;
  } entry_t;

  entry_t           mem_q [DEPTH];
  entry_t           mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push, pop;
  entry_t           head;

  assign q.in_ready  = (count_q != CNT_W'(DEPTH));
  assign q.out_valid = (count_q != '0);
  assign push        = q.in_valid & q.in_ready;
  assign pop         = q.out_valid & q.out_ready;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (q.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = '{pc: q.in_pc, instr: q.in_instr};
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; empty-queue outputs are masked below instead.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  assign head        = q.out_valid ? mem_q[rd_ptr_q] : '0;
  assign q.out_instr = head.instr;
  assign q.out_pc    = head.pc;
  assign q.count     = count_q;

  instr_field_decode u_decode (
    .instr       (head.instr),
    .opcode      (q.opcode),
    .rs          (q.rs),
    .rt          (q.rt),
    .rd          (q.rd),
    .shamt       (q.shamt),
    .funct       (q.funct),
    .imm         (q.imm),
    .imm_sext    (q.imm_sext),
    .jump_target (q.jump_target)
  );

endmodule

// File: tb/tb_instr_queue.sv
// Random and directed stimulus for instr_queue against a queue-based scoreboard model.
module tb_instr_queue;

  localparam int DEPTH = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  instr_queue_if #(.DATA_W(32), .PC_W(32), .DEPTH(DEPTH)) q ();

  instr_queue #(.DATA_W(32), .DEPTH(DEPTH), .PC_W(32)) dut (
    .clock (clock),
    .reset (reset),
    .q     (q)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  ent_t exp_q[$];
  int   checks = 0;
  int   passes = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // One cycle of stimulus; the model learns what the queue accepted at the edge.
  task automatic step(input logic iv, input logic [31:0] ins, input logic [31:0] pc,
                      input logic ordy, input logic fl, input logic rs);
    logic acc;
    q.in_valid  = iv;
    q.in_instr  = ins;
    q.in_pc     = pc;
    q.out_ready = ordy;
    q.flush     = fl;
    reset       = rs;
    acc = iv && !fl && !rs && (exp_q.size() < DEPTH);
    @(posedge clock);
    if (rs || fl) exp_q.delete();
    else if (acc) exp_q.push_back('{instr: ins, pc: pc});
    #1;
  endtask

  // Monitor: every mid-cycle compares status and head against the model, pops on handshake.
  initial begin
    ent_t        h;
    logic [31:0] w, immv, sext;
    forever begin
      @(negedge clock);
      if (reset === 1'b0) begin
        if (exp_q.size() != 0) h = exp_q[0];
        else h = '{instr: 32'h0, pc: 32'h0};
        w    = h.instr;
        immv = w & 32'hFFFF;
        sext = (immv >= 32'h8000) ? immv - 32'h10000 : immv;
        chk("count",       q.count,       exp_q.size());
        chk("out_valid",   q.out_valid,   exp_q.size() != 0);
        chk("in_ready",    q.in_ready,    exp_q.size() < DEPTH);
        chk("out_instr",   q.out_instr,   w);
        chk("out_pc",      q.out_pc,      h.pc);
        chk("opcode",      q.opcode,      w >> 26);
        chk("rs",          q.rs,          (w >> 21) & 32'h1F);
        chk("rt",          q.rt,          (w >> 16) & 32'h1F);
        chk("rd",          q.rd,          (w >> 11) & 32'h1F);
        chk("shamt",       q.shamt,       (w >> 6) & 32'h1F);
        chk("funct",       q.funct,       w & 32'h3F);
        chk("imm",         q.imm,         immv);
        chk("imm_sext",    q.imm_sext,    sext);
        chk("jump_target", q.jump_target, w & 32'h3FF_FFFF);
        if (exp_q.size() != 0 && q.out_ready && !q.flush) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    q.flush = 1'b0; q.in_valid = 1'b0; q.in_instr = '0; q.in_pc = '0; q.out_ready = 1'b0;
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);

    // lw $2, 4($1)
    step(1, 32'h8C22_0004, 32'h100, 0, 0, 0);
    chk("t1_out_valid", q.out_valid, 1);
    chk("t1_opcode",    q.opcode,    6'h23);
    chk("t1_rs",        q.rs,        1);
    chk("t1_rt",        q.rt,        2);
    chk("t1_imm",       q.imm,       4);
    chk("t1_imm_sext",  q.imm_sext,  32'h0000_0004);
    chk("t1_count",     q.count,     1);
    chk("t1_out_pc",    q.out_pc,    32'h100);

    step(1, 32'h2021_FFFF, 32'h104, 1, 0, 0);
    chk("t2_imm_sext",  q.imm_sext,  32'hFFFF_FFFF);
    chk("t2_rd",        q.rd,        31);
    step(1, 32'h0274_8020, 32'h108, 1, 0, 0);
    chk("t2_funct",     q.funct,     6'h20);
    chk("t2_rd_r",      q.rd,        16);
    chk("t2_shamt",     q.shamt,     0);
    step(0, 0, 0, 1, 0, 0);

    // Fill, overfill, drain.
    for (int i = 0; i < DEPTH; i++) step(1, 32'hA000_0000 + i, 32'h200 + 4*i, 0, 0, 0);
    chk("t3_in_ready", q.in_ready, 0);
    chk("t3_count",    q.count,    DEPTH);
    step(1, 32'hDEAD_BEEF, 32'h2FC, 0, 0, 0);
    chk("t3_full_count", q.count,     DEPTH);
    chk("t3_full_head",  q.out_instr, 32'hA000_0000);
    for (int i = 0; i < DEPTH; i++) step(0, 0, 0, 1, 0, 0);
    chk("t3_empty_valid", q.out_valid, 0);
    chk("t3_empty_instr", q.out_instr, 0);

    // Steady push+pop at count 2 across pointer wrap.
    step(1, 32'hB000_0000, 32'h300, 0, 0, 0);
    step(1, 32'hB000_0001, 32'h304, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      step(1, 32'hB000_0002 + i, 32'h308 + 4*i, 1, 0, 0);
      chk("t4_count", q.count, 2);
    end
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);

    // Flush at count 3 with push and pop requested.
    for (int i = 0; i < 3; i++) step(1, 32'hC000_0000 + i, 32'h400 + 4*i, 0, 0, 0);
    step(1, 32'hC0FF_EE00, 32'h40C, 1, 1, 0);
    chk("t5_count",     q.count,     0);
    chk("t5_out_valid", q.out_valid, 0);
    chk("t5_in_ready",  q.in_ready,  1);
    step(0, 0, 0, 0, 0, 0);
    step(1, 32'hC000_0010, 32'h500, 0, 0, 0);
    chk("t5_post_head", q.out_instr, 32'hC000_0010);
    step(0, 0, 0, 1, 0, 0);

    // Reset mid-stream with a push pending.
    step(1, 32'hD000_0000, 32'h600, 0, 0, 0);
    step(1, 32'hD000_0001, 32'h604, 0, 0, 0);
    step(1, 32'hD000_0002, 32'h608, 1, 0, 1);
    chk("t6_out_valid", q.out_valid, 0);
    chk("t6_in_ready",  q.in_ready,  1);
    chk("t6_count",     q.count,     0);
    chk("t6_out_instr", q.out_instr, 0);
    chk("t6_out_pc",    q.out_pc,    0);
    chk("t6_imm_sext",  q.imm_sext,  0);

    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 3) != 0, $urandom, $urandom,
           $urandom_range(0, 2) != 0, $urandom_range(0, 24) == 0,
           $urandom_range(0, 149) == 0);
    end
    step(0, 0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
